// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Holds opcode constants, the alu_op encodings understood by the ALU function
// decoder, the alu_src_b / pc_source mux encodings, the FSM state encoding and
// the instruction classes produced by the opcode decoder.
package multicycle_control_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpSlti  = 6'b001010;

    // alu_op encodings consumed by the ALU function decoder
    localparam logic [2:0] AluOpAdd   = 3'b000;
    localparam logic [2:0] AluOpBeq   = 3'b001;
    localparam logic [2:0] AluOpRType = 3'b010;
    localparam logic [2:0] AluOpAddi  = 3'b011;
    localparam logic [2:0] AluOpOri   = 3'b100;
    localparam logic [2:0] AluOpAndi  = 3'b101;
    localparam logic [2:0] AluOpSlti  = 3'b110;

    // ALU operand B select
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // PC source select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRExec   = 4'd6,
        StRWb     = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StIExec   = 4'd10,
        StIWb     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ClsLoad,
        ClsStore,
        ClsRType,
        ClsBranch,
        ClsJump,
        ClsImm,
        ClsIllegal
    } instr_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multi-cycle control unit.
// master: the control FSM (reads opcode/zero/mem_ready, drives every control).
// slave : the datapath / memory side.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;

    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       alu_op;
    logic             instr_done;
    logic [CNT_W-1:0] retired;
    logic             illegal;
    logic [3:0]       state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
               alu_op, instr_done, retired, illegal, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
               alu_op, instr_done, retired, illegal, state_dbg
    );

endinterface

// File: rtl/multicycle_control_op_decode.sv
// Combinational opcode decoder for the multi-cycle control unit.
// Maps opcode to an instruction class, the immediate-arithmetic alu_op and an
// illegal-opcode flag.
module multicycle_control_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   opcode,
    output instr_class_t iclass,
    output logic [2:0]   imm_alu_op,
    output logic         illegal
);

    always_comb begin
        iclass     = ClsIllegal;
        imm_alu_op = AluOpAdd;
        case (opcode)
            OpLw:    iclass = ClsLoad;
            OpSw:    iclass = ClsStore;
            OpRType: iclass = ClsRType;
            OpBeq:   iclass = ClsBranch;
            OpJ:     iclass = ClsJump;
            OpAddi:  begin iclass = ClsImm; imm_alu_op = AluOpAddi; end
            OpOri:   begin iclass = ClsImm; imm_alu_op = AluOpOri;  end
            OpAndi:  begin iclass = ClsImm; imm_alu_op = AluOpAndi; end
            OpSlti:  begin iclass = ClsImm; imm_alu_op = AluOpSlti; end
            default: iclass = ClsIllegal;
        endcase
        illegal = (iclass == ClsIllegal);
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS-subset datapath.
// Ports: clk, rst (async, active high) and bus (multicycle_control_if.master):
// opcode/zero/mem_ready in; datapath mux selects, write enables, alu_op,
// instr_done pulse, retired counter, sticky illegal flag and state_dbg out.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;

    instr_class_t iclass;
    logic [2:0]   imm_alu_op;
    logic         dec_illegal;

    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, retire;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;

    // zero feeds the datapath PC-write logic, not this FSM
    logic unused_zero;
    assign unused_zero = bus.zero;

    multicycle_control_op_decode u_op_decode (
        .opcode     (bus.opcode),
        .iclass     (iclass),
        .imm_alu_op (imm_alu_op),
        .illegal    (dec_illegal)
    );

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        pc_source     = PcSrcAlu;
        alu_op        = AluOpAdd;
        retire        = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                // PC+4 and IR load only commit once the fetch completes
                pc_write  = bus.mem_ready;
                ir_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;  // precompute branch target
                case (iclass)
                    ClsLoad, ClsStore: state_d = StMemAddr;
                    ClsRType:          state_d = StRExec;
                    ClsBranch:         state_d = StBranch;
                    ClsJump:           state_d = StJump;
                    ClsImm:            state_d = StIExec;
                    default:           state_d = StFetch;
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = (iclass == ClsStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = AluOpRType;
                state_d   = StRWb;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = AluOpBeq;
                pc_write_cond = 1'b1;
                pc_source     = PcSrcAluOut;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcSrcJump;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = imm_alu_op;
                state_d   = StIWb;
            end
            StIWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (state_q == StDecode && dec_illegal) illegal_q <= 1'b1;
        end
    end

    // Reset is asynchronous, so write enables are masked combinationally to
    // keep FETCH's mem_read/pc_write from leaking out while rst is high.
    assign bus.pc_write      = pc_write & ~rst;
    assign bus.pc_write_cond = pc_write_cond & ~rst;
    assign bus.ir_write      = ir_write & ~rst;
    assign bus.mem_read      = mem_read & ~rst;
    assign bus.mem_write     = mem_write & ~rst;
    assign bus.reg_write     = reg_write & ~rst;
    assign bus.i_or_d        = i_or_d;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.pc_source     = pc_source;
    assign bus.alu_op        = alu_op;
    assign bus.instr_done    = retire & ~rst;
    assign bus.retired       = retired_q;
    assign bus.illegal       = illegal_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a path-based instruction model
// checked every cycle, plus directed instructions with literal expectations.
// A second instance with a 2-bit counter shares the stimulus to exercise wrap.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(16)) bus ();
    multicycle_control_if #(.CNT_W(2))  bus_s ();

    multicycle_control #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multicycle_control #(.CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.opcode    = bus.opcode;
    assign bus_s.zero      = bus.zero;
    assign bus_s.mem_ready = bus.mem_ready;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_illegal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
            6'b001000, 6'b001101, 6'b001100, 6'b001010: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] op);
        case (op)
            6'b001000: return 3'b011;
            6'b001101: return 3'b100;
            6'b001100: return 3'b101;
            6'b001010: return 3'b110;
            default:   return 3'b000;
        endcase
    endfunction

    // Expected control table: {pc_write, pc_write_cond, ir_write, mem_read,
    // mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a,
    // alu_src_b[1:0], pc_source[1:0], alu_op[2:0]}
    function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
        logic pw, pwc, irw, mrd, mwr, iod, rw, rd, m2r, sa;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pw, pwc, irw, mrd, mwr, iod, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; pw = mr; irw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iod = 1; end
            6:  begin sa = 1; ao = 3'b010; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ao = imm_op(op); end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, irw, mrd, mwr, iod, rw, rd, m2r, sa, sb, ps, ao};
    endfunction

    // Model: an instruction is FETCH, DECODE, then a class-specific path of
    // states; MEM_RD and MEM_WR repeat while mem_ready is low.
    int m_state = 0;
    int m_ret   = 0;
    bit m_ill   = 1'b0;
    int path[$];

    always @(negedge clk) begin
        logic [16:0] act;
        bit stall;
        bit done_exp;
        if (rst) begin
            check("rst_state", 32'(bus.state_dbg), 0);
            check("rst_write_enables", 32'({bus.pc_write, bus.pc_write_cond, bus.ir_write,
                                            bus.mem_write, bus.reg_write, bus.mem_read}), 0);
            check("rst_instr_done", 32'(bus.instr_done), 0);
            m_state = 0;
            m_ret   = 0;
            m_ill   = 1'b0;
            path.delete();
        end else begin
            stall    = (m_state == 3 || m_state == 5) && !bus.mem_ready;
            done_exp = (m_state > 1) && (path.size() == 0) && !stall;
            act = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read, bus.mem_write,
                   bus.i_or_d, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                   bus.alu_src_b, bus.pc_source, bus.alu_op};
            check("state", 32'(bus.state_dbg), m_state);
            check("controls", 32'(act), 32'(exp_ctrl(m_state, bus.mem_ready, bus.opcode)));
            check("instr_done", 32'(bus.instr_done), 32'(done_exp));
            check("retired", 32'(bus.retired), m_ret & 32'hFFFF);
            check("retired_w2", 32'(bus_s.retired), m_ret % 4);
            check("illegal", 32'(bus.illegal), 32'(m_ill));
            if (m_state == 0) begin
                if (bus.mem_ready) m_state = 1;
            end else if (m_state == 1) begin
                case (bus.opcode)
                    6'b100011: begin m_state = 2;  path = {3, 4}; end
                    6'b101011: begin m_state = 2;  path = {5};    end
                    6'b000000: begin m_state = 6;  path = {7};    end
                    6'b000100: m_state = 8;
                    6'b000010: m_state = 9;
                    6'b001000, 6'b001101, 6'b001100, 6'b001010: begin
                        m_state = 10;
                        path    = {11};
                    end
                    default: begin m_state = 0; m_ill = 1'b1; end
                endcase
            end else if (!stall) begin
                if (path.size() == 0) begin
                    m_ret++;
                    m_state = 0;
                end else begin
                    m_state = path.pop_front();
                end
            end
        end
    end

    logic [31:0] seq_pk;
    logic [2:0]  iexec_op;
    logic        wb_m2r;

    // Called just after a rising edge with the DUT in FETCH; returns just
    // after the rising edge that starts the next FETCH.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                             output int cycles);
        bit done;
        logic [3:0] st;
        done   = 1'b0;
        cycles = 0;
        seq_pk = '0;
        bus.opcode = op;
        for (int i = 0; i < 40 && !done; i++) begin
            st = bus.state_dbg;
            if (st == 4'd0 && fs > 0) begin
                bus.mem_ready = 1'b0;
                fs--;
            end else if ((st == 4'd3 || st == 4'd5) && ms > 0) begin
                bus.mem_ready = 1'b0;
                ms--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            @(negedge clk);
            cycles++;
            seq_pk = {seq_pk[27:0], bus.state_dbg};
            if (bus.state_dbg == 4'd10) iexec_op = bus.alu_op;
            if (bus.state_dbg == 4'd4) wb_m2r = bus.mem_to_reg;
            done = bus.instr_done || (bus.state_dbg == 4'd1 && op_illegal(op));
            @(posedge clk);
            #1;
        end
        if (!done) check("instr_timeout", 0, 1);
    endtask

    initial begin
        int  cyc;
        bit  found;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_instr(6'b000000, 0, 0, cyc);         // add
        check("add_cycles", cyc, 4);
        check("add_states", seq_pk, 32'h0167);
        check("add_retired", 32'(bus.retired), 1);

        run_instr(6'b100011, 0, 2, cyc);         // lw, 2 stall cycles in MEM_RD
        check("lw_cycles", cyc, 7);
        check("lw_mem_to_reg", 32'(wb_m2r), 1);
        check("lw_retired", 32'(bus.retired), 2);

        run_instr(6'b101011, 0, 0, cyc);         // sw
        check("sw_cycles", cyc, 4);
        check("sw_states", seq_pk, 32'h0125);
        check("w2_before_wrap", 32'(bus_s.retired), 3);

        run_instr(6'b000100, 0, 0, cyc);         // beq
        check("beq_cycles", cyc, 3);
        check("beq_states", seq_pk, 32'h018);
        check("w2_wrapped", 32'(bus_s.retired), 0);

        run_instr(6'b001101, 0, 0, cyc);         // ori
        check("ori_cycles", cyc, 4);
        check("ori_alu_op", 32'(iexec_op), 32'b100);

        run_instr(6'b001010, 1, 0, cyc);         // slti, 1 fetch stall
        check("slti_cycles", cyc, 5);
        check("slti_alu_op", 32'(iexec_op), 32'b110);

        run_instr(6'b000010, 0, 0, cyc);         // j
        check("j_cycles", cyc, 3);
        check("j_states", seq_pk, 32'h019);
        check("j_retired", 32'(bus.retired), 7);

        run_instr(6'b111111, 0, 0, cyc);         // illegal
        check("illegal_cycles", cyc, 2);
        check("illegal_set", 32'(bus.illegal), 1);
        check("illegal_no_retire", 32'(bus.retired), 7);

        run_instr(6'b000000, 0, 0, cyc);         // add after illegal
        check("illegal_held", 32'(bus.illegal), 1);
        check("add2_retired", 32'(bus.retired), 8);

        run_instr(6'b101011, 0, 1, cyc);         // sw, 1 stall in MEM_WR
        check("sw_stall_cycles", cyc, 5);
        check("sw_stall_retired", 32'(bus.retired), 9);

        // Reset in the middle of BRANCH
        bus.opcode    = 6'b000100;
        bus.mem_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (bus.state_dbg == 4'd8) found = 1'b1;
        end
        check("reach_branch", 32'(found), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(bus.state_dbg), 0);
        check("rst_mid_we", 32'({bus.pc_write, bus.pc_write_cond, bus.ir_write,
                                 bus.mem_write, bus.reg_write, bus.mem_read}), 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_retired", 32'(bus.retired), 0);
        check("rst_illegal", 32'(bus.illegal), 0);

        run_instr(6'b000000, 0, 0, cyc);         // add after reset
        check("post_rst_cycles", cyc, 4);
        check("post_rst_retired", 32'(bus.retired), 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
